// File: rtl/mini_src_control_unit_if.sv
// mini_src_control_unit_if: IR/condition inputs and datapath strobes between the control unit and the Mini SRC datapath.
interface mini_src_control_unit_if;
    logic [31:0] ir;
    logic con_ff, start, stop, run;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic p_out, pc_en, mar_en, mdr_en, mdr_out, read, write, ir_en;
    logic y_en, zlo_en, zhi_en, zlo_out, hi_out, lo_out, c_out;
    logic in_port_out, out_port_en, con_in;
    logic [4:0] alu_control;
    modport master (
        input  ir, con_ff, start, stop,
        output run, gra, grb, grc, r_in, r_out, ba_out,
        output p_out, pc_en, mar_en, mdr_en, mdr_out, read, write, ir_en,
        output y_en, zlo_en, zhi_en, zlo_out, hi_out, lo_out, c_out,
        output in_port_out, out_port_en, con_in, alu_control
    );
    modport slave (
        output ir, con_ff, start, stop,
        input  run, gra, grb, grc, r_in, r_out, ba_out,
        input  p_out, pc_en, mar_en, mdr_en, mdr_out, read, write, ir_en,
        input  y_en, zlo_en, zhi_en, zlo_out, hi_out, lo_out, c_out,
        input  in_port_out, out_port_en, con_in, alu_control
    );
endinterface

// File: rtl/mini_src_control_unit.sv
// mini_src_control_unit: hard-wired Mini SRC sequencer decoding step count, IR opcode and CON into datapath strobes.
module mini_src_control_unit #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] ALU_AND = 5'b00101,
    parameter logic [4:0] ALU_OR  = 5'b00110,
    parameter logic [4:0] ALU_INC = 5'b11011
) (
    input logic clk,
    input logic clr,
    mini_src_control_unit_if.master bus
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;
    step_t step;
    logic halted, stop_lat, run, zen, last, go_halt;
    logic is_rrr, is_imm, is_ldi, is_ld, is_st, is_br, is_halt;
    logic [4:0] op, alu_imm;
    assign op      = bus.ir[31:27];
    assign is_rrr  = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    assign is_imm  = op inside {5'b01100, 5'b01101, 5'b01110};
    assign is_ldi  = op == 5'b00001;
    assign is_ld   = op == 5'b00000;
    assign is_st   = op == 5'b00010;
    assign is_br   = op == 5'b10010;
    assign is_halt = op == 5'b11010;
    assign alu_imm = op == 5'b01101 ? ALU_AND : op == 5'b01110 ? ALU_OR : ALU_ADD;
    assign last = (step == T5 && (is_rrr || is_imm || is_ldi)) ||
                  (step == T7 && (is_ld || is_st)) ||
                  (step == T6 && is_br) ||
                  (step == T3 && !(is_rrr || is_imm || is_ldi || is_ld || is_st || is_br));
    assign go_halt = stop_lat || is_halt;
    // clr gates run so strobes drop the instant reset asserts, even mid-write
    assign run = clr && !halted;
    assign bus.run = run;
    assign bus.zlo_en = zen;
    assign bus.zhi_en = zen;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            step     <= T0;
            halted   <= 1'b0;
            stop_lat <= 1'b0;
        end else if (halted) begin
            halted   <= !bus.start;
            stop_lat <= 1'b0;
        end else if (last) begin
            step     <= T0;
            halted   <= go_halt;
            stop_lat <= go_halt ? 1'b0 : stop_lat || bus.stop;
        end else begin
            step     <= step_t'(step + 3'd1);
            stop_lat <= stop_lat || bus.stop;
        end
    end
    always_comb begin
        {bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out, bus.ba_out} = '0;
        {bus.p_out, bus.pc_en, bus.mar_en, bus.mdr_en, bus.mdr_out, bus.read, bus.write, bus.ir_en} = '0;
        {bus.y_en, bus.zlo_out, bus.hi_out, bus.lo_out, bus.c_out} = '0;
        {bus.in_port_out, bus.out_port_en, bus.con_in} = '0;
        zen = 1'b0;
        bus.alu_control = '0;
        if (run) begin
            case (step)
                T0: begin
                    {bus.p_out, bus.mar_en, zen} = '1;
                    bus.alu_control = ALU_INC;
                end
                T1: {bus.zlo_out, bus.pc_en, bus.read, bus.mdr_en} = '1;
                T2: {bus.mdr_out, bus.ir_en} = '1;
                T3: begin
                    if (is_rrr || is_imm) {bus.grb, bus.r_out, bus.y_en} = '1;
                    if (is_ldi || is_ld || is_st) {bus.grb, bus.ba_out, bus.y_en} = '1;
                    if (is_br) {bus.gra, bus.r_out, bus.con_in} = '1;
                    if (op == 5'b10011) {bus.gra, bus.r_out, bus.pc_en} = '1;
                    if (op == 5'b10101) {bus.in_port_out, bus.gra, bus.r_in} = '1;
                    if (op == 5'b10110) {bus.gra, bus.r_out, bus.out_port_en} = '1;
                    if (op == 5'b10111) {bus.hi_out, bus.gra, bus.r_in} = '1;
                    if (op == 5'b11000) {bus.lo_out, bus.gra, bus.r_in} = '1;
                end
                T4: begin
                    if (is_rrr) begin
                        {bus.grc, bus.r_out, zen} = '1;
                        bus.alu_control = op;
                    end
                    if (is_imm || is_ldi || is_ld || is_st) begin
                        {bus.c_out, zen} = '1;
                        bus.alu_control = alu_imm;
                    end
                    if (is_br) {bus.p_out, bus.y_en} = '1;
                end
                T5: begin
                    if (is_rrr || is_imm || is_ldi) {bus.zlo_out, bus.gra, bus.r_in} = '1;
                    if (is_ld || is_st) {bus.zlo_out, bus.mar_en} = '1;
                    if (is_br) begin
                        {bus.c_out, zen} = '1;
                        bus.alu_control = ALU_ADD;
                    end
                end
                T6: begin
                    if (is_ld) {bus.read, bus.mdr_en} = '1;
                    if (is_st) {bus.gra, bus.r_out, bus.mdr_en} = '1;
                    if (is_br && bus.con_ff) {bus.zlo_out, bus.pc_en} = '1;
                end
                T7: begin
                    if (is_ld) {bus.mdr_out, bus.gra, bus.r_in} = '1;
                    if (is_st) bus.write = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mini_src_control_unit.sv
// tb_mini_src_control_unit: randomized bench comparing every cycle's strobes against a per-instruction microprogram table.
module tb_mini_src_control_unit;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int checks = 0;
    int errors = 0;
    bit latch = 1'b0;
    mini_src_control_unit_if bus ();
    mini_src_control_unit dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;

    localparam logic [29:0] RUN = 30'd1 << 29, GRA = 30'd1 << 28, GRB = 30'd1 << 27, GRC = 30'd1 << 26;
    localparam logic [29:0] RIN = 30'd1 << 25, ROUT = 30'd1 << 24, BAOUT = 30'd1 << 23, POUT = 30'd1 << 22;
    localparam logic [29:0] PCEN = 30'd1 << 21, MAREN = 30'd1 << 20, MDREN = 30'd1 << 19, MDROUT = 30'd1 << 18;
    localparam logic [29:0] READ = 30'd1 << 17, WRITE = 30'd1 << 16, IREN = 30'd1 << 15, YEN = 30'd1 << 14;
    localparam logic [29:0] ZEN = 30'd3 << 12, ZLOOUT = 30'd1 << 11, HIOUT = 30'd1 << 10, LOOUT = 30'd1 << 9;
    localparam logic [29:0] COUT = 30'd1 << 8, INOUT = 30'd1 << 7, OUTEN = 30'd1 << 6, CONIN = 30'd1 << 5;
    localparam logic [29:0] A_ADD = 30'd3, A_AND = 30'd5, A_OR = 30'd6, A_INC = 30'd27;

    logic [29:0] obs;
    assign obs = {bus.run, bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out, bus.ba_out, bus.p_out,
                  bus.pc_en, bus.mar_en, bus.mdr_en, bus.mdr_out, bus.read, bus.write, bus.ir_en,
                  bus.y_en, bus.zlo_en, bus.zhi_en, bus.zlo_out, bus.hi_out, bus.lo_out, bus.c_out,
                  bus.in_port_out, bus.out_port_en, bus.con_in, bus.alu_control};

    // Microprogram of one instruction: list of strobe sets, one per step, ending at its last step
    task automatic build(input logic [4:0] op, input bit con, output logic [29:0] seq[8], output int n);
        seq = '{default: '0};
        seq[0] = POUT | MAREN | ZEN | A_INC;
        seq[1] = ZLOOUT | PCEN | READ | MDREN;
        seq[2] = MDROUT | IREN;
        n = 4;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                seq[3] = GRB | ROUT | YEN; seq[4] = GRC | ROUT | ZEN | 30'(op); seq[5] = ZLOOUT | GRA | RIN; n = 6;
            end
            5'd1, 5'd12, 5'd13, 5'd14: begin
                seq[3] = (op == 5'd1) ? (GRB | BAOUT | YEN) : (GRB | ROUT | YEN);
                seq[4] = COUT | ZEN | (op == 5'd13 ? A_AND : op == 5'd14 ? A_OR : A_ADD);
                seq[5] = ZLOOUT | GRA | RIN; n = 6;
            end
            5'd0, 5'd2: begin
                seq[3] = GRB | BAOUT | YEN; seq[4] = COUT | ZEN | A_ADD; seq[5] = ZLOOUT | MAREN;
                seq[6] = (op == 5'd0) ? (READ | MDREN) : (GRA | ROUT | MDREN);
                seq[7] = (op == 5'd0) ? (MDROUT | GRA | RIN) : WRITE; n = 8;
            end
            5'd18: begin
                seq[3] = GRA | ROUT | CONIN; seq[4] = POUT | YEN; seq[5] = COUT | ZEN | A_ADD;
                seq[6] = con ? (ZLOOUT | PCEN) : '0; n = 7;
            end
            5'd19: seq[3] = GRA | ROUT | PCEN;
            5'd21: seq[3] = INOUT | GRA | RIN;
            5'd22: seq[3] = GRA | ROUT | OUTEN;
            5'd23: seq[3] = HIOUT | GRA | RIN;
            5'd24: seq[3] = LOOUT | GRA | RIN;
            default: seq[3] = '0;
        endcase
    endtask

    // Runs one instruction from T0 (called at posedge+1); checks each step at negedge
    task automatic run_instr(input string tag, input logic [4:0] op, input bit con, input int stop_at,
                             input int abort_at, output bit halted);
        logic [29:0] seq[8];
        int n;
        build(op, con, seq, n);
        halted = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.ir = {op, 27'($urandom)};
            bus.con_ff = (i == 6) ? con : 1'($urandom);
            bus.stop = (i == stop_at);
            bus.start = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== (RUN | seq[i])) begin
                errors++;
                $display("FAIL %s op=%0d T%0d: got %h expected %h", tag, op, i, obs, RUN | seq[i]);
            end
            if (i == abort_at) begin
                #2 clr = 1'b0;
                #1 checks++;
                if (obs !== 30'd0) begin
                    errors++;
                    $display("FAIL %s clr_async op=%0d T%0d: got %h expected 0", tag, op, i, obs);
                end
                bus.stop = 1'b0;
                bus.start = 1'b0;
                latch = 1'b0;
                return;
            end
            if (i == n - 1) begin
                halted = latch || op == 5'd26;
                latch = halted ? 1'b0 : (latch || bus.stop);
            end else latch = latch || bus.stop;
            @(posedge clk);
            #1;
        end
        bus.stop = 1'b0;
        bus.start = 1'b0;
    endtask

    // Stays halted for n cycles under noise, then resumes with start (stop raised at the same time)
    task automatic halt_hold(input int n);
        for (int i = 0; i <= n; i++) begin
            bus.ir = $urandom;
            bus.con_ff = 1'($urandom);
            bus.stop = (i == n) ? 1'b1 : 1'($urandom);
            bus.start = (i == n);
            @(negedge clk);
            checks++;
            if (obs !== 30'd0) begin
                errors++;
                $display("FAIL halt_hold cycle %0d: got %h expected 0", i, obs);
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        latch = 1'b0;
    endtask

    task automatic test_reset();
        bus.ir = 32'h18918000; bus.con_ff = 1'b0; bus.start = 1'b1; bus.stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 30'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected 0", i, obs);
            end
            bus.ir = $urandom;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        clr = 1'b1;
        latch = 1'b0;
    endtask

    task automatic test_alu_ops();
        bit h;
        logic [4:0] ops[8] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd1};
        foreach (ops[k]) run_instr("alu", ops[k], 1'b0, -1, -1, h);
    endtask

    task automatic test_mem();
        bit h;
        run_instr("ld", 5'd0, 1'b0, -1, -1, h);
        run_instr("st", 5'd2, 1'b0, -1, -1, h);
    endtask

    task automatic test_branch();
        bit h;
        run_instr("br_con0", 5'd18, 1'b0, -1, -1, h);
        run_instr("br_con1", 5'd18, 1'b1, -1, -1, h);
    endtask

    task automatic test_single_step();
        bit h;
        logic [4:0] ops[7] = '{5'd19, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd7};
        foreach (ops[k]) run_instr("single", ops[k], 1'b0, -1, -1, h);
    endtask

    task automatic test_stop_start();
        bit h;
        run_instr("stop_add", 5'd3, 1'b0, 4, -1, h);
        if (h) halt_hold(3);
        run_instr("after_start", 5'd3, 1'b0, -1, -1, h);
        run_instr("stop_ld", 5'd0, 1'b0, 2, -1, h);
        if (h) halt_hold(1);
        run_instr("stop_end", 5'd25, 1'b0, 3, -1, h);
        run_instr("halt_next", 5'd22, 1'b0, -1, -1, h);
        if (h) halt_hold(2);
    endtask

    task automatic test_halt_op();
        bit h;
        run_instr("halt_op", 5'd26, 1'b0, -1, -1, h);
        if (h) halt_hold(4);
        run_instr("post_halt", 5'd24, 1'b0, -1, -1, h);
    endtask

    task automatic test_clr_abort();
        bit h;
        run_instr("st_abort", 5'd2, 1'b0, -1, 6, h);
        @(posedge clk);
        #1 checks++;
        if (obs !== 30'd0 || bus.write !== 1'b0) begin
            errors++;
            $display("FAIL clr_hold: got %h expected 0", obs);
        end
        clr = 1'b1;
        run_instr("after_clr", 5'd2, 1'b0, -1, -1, h);
    endtask

    task automatic test_random();
        bit h;
        logic [4:0] ops[20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14,
                                5'd18, 5'd19, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd7, 5'd31};
        for (int k = 0; k < 60; k++) begin
            run_instr("random", ops[$urandom_range(19, 0)], 1'($urandom),
                      ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1, -1, h);
            if (h) halt_hold($urandom_range(3, 0));
        end
    endtask

    initial begin
        bus.ir = '0; bus.con_ff = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch();
        test_single_step();
        test_stop_start();
        test_halt_op();
        test_clr_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hard-wired control sequencer directly upstream of the Mini SRC datapath; drives every datapath strobe from the current step count, IR opcode and CON flag.
- Runs a 3-step fetch (T0-T2) and up to 5 execute steps (T3-T7).
- Supports start/stop/halt.
- All control outputs are combinational decodes of registered state plus `ir`; the only registers are the step counter, the halted flag and the stop latch.

Parameters:
- ALU_ADD, 5'b00011, ALU code for add/address calculation.
- ALU_AND, 5'b00101, ALU code for AND.
- ALU_OR, 5'b00110, ALU code for OR.
- ALU_INC, 5'b11011, ALU code for PC+1 (Y ignored).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-low reset.
- ir  input  32  IR register contents; opcode ir[31:27].
- con_ff  input  1  CON flip-flop output (branch condition).
- start  input  1  resume from HALT.
- stop  input  1  request halt at the next instruction boundary.
- run  output  1  high while sequencing, low in HALT/reset.
- gra, grb, grc, r_in, r_out, ba_out  output  1 each  select/encode controls.
- p_out, pc_en, mar_en, mdr_en, mdr_out, read, write, ir_en  output  1 each  PC/memory strobes.
- y_en, zlo_en, zhi_en, zlo_out, hi_out, lo_out, c_out  output  1 each  ALU-path strobes.
- in_port_out, out_port_en, con_in  output  1 each  I/O and CON strobes.
- alu_control  output  5  ALU operation code; 0 when unused.

Behaviour:
- **Reset.** While clr=0: step=T0, halted=0, stop latch=0, run=0, all strobes 0, alu_control=0. The first rising edge after release executes T0 with run=1.
- **Strobe rule.** Each strobe is high only in the steps listed below. "Zen" means zlo_en and zhi_en are both high.
- **Fetch** (all opcodes):
  - T0: p_out, mar_en, alu_control=ALU_INC, Zen.
  - T1: zlo_out, pc_en, read, mdr_en.
  - T2: mdr_out, ir_en.
- **Execute** (opcode = ir[31:27], sampled each cycle from the already-loaded IR):
  - add 00011, sub 00100, and 00101, or 00110:
    - T3: grb, r_out, y_en.
    - T4: grc, r_out, alu_control=opcode, Zen.
    - T5: zlo_out, gra, r_in; end.
  - addi 01100 / andi 01101 / ori 01110:
    - T3: grb, r_out, y_en.
    - T4: c_out, alu_control=ALU_ADD / ALU_AND / ALU_OR, Zen.
    - T5: zlo_out, gra, r_in; end.
  - ldi 00001: as addi, but T3 uses grb, ba_out, y_en (R0 reads as 0 via BAout).
  - ld 00000 and st 00010, T3-T5:
    - T3: grb, ba_out, y_en.
    - T4: c_out, ALU_ADD, Zen.
    - T5: zlo_out, mar_en.
  - ld then continues:
    - T6: read, mdr_en.
    - T7: mdr_out, gra, r_in; end.
  - st then continues:
    - T6: gra, r_out, mdr_en (read=0 so the MDR takes the bus).
    - T7: write; end.
  - br 10010:
    - T3: gra, r_out, con_in.
    - T4: p_out, y_en.
    - T5: c_out, ALU_ADD, Zen.
    - T6: if con_ff=1 then zlo_out and pc_en, else no strobes; end. con_ff is sampled in T6 only.
  - jr 10011: T3: gra, r_out, pc_en; end.
  - in 10101: T3: in_port_out, gra, r_in; end.
  - out 10110: T3: gra, r_out, out_port_en; end.
  - mfhi 10111: T3: hi_out, gra, r_in; end.
  - mflo 11000: T3: lo_out, gra, r_in; end.
  - nop 11001 and every unlisted opcode: T3 with no strobes; end.
  - halt 11010: T3 with no strobes; next state HALT.
- **Step counter.** The counter advances by 1 each cycle.
  - At an "end" step the next state is T0.
  - If the stop latch is set at an "end" step, the next state is HALT instead.
- **Stop latch.** Set by stop=1 in any cycle; cleared on entry to HALT. A stop raised mid-instruction never truncates the instruction.
- **HALT.** run=0, all strobes 0, state held. start=1 → T0 next cycle with halted=0. start is ignored outside HALT.
- **Simultaneous events.**
  - stop=1 and start=1 in the same HALT cycle: start wins, the stop latch is cleared, and the next state is T0.
  - clr asserted in any step, HALT included: immediate return to the reset state. Any write or pc_en in flight is dropped combinationally.
- **Exclusivity invariant.** At most one bus driver is active per cycle: r_out, ba_out, p_out, mdr_out, zlo_out, hi_out, lo_out, c_out, in_port_out.
- **Counter width.** The step counter is 3 bits and never wraps past T7: every path ends by T7.

Test Plan:
1. Release clr with ir=0x18918000 (add r1,r2,r3) → T0..T5 over 6 cycles.
   - T4: alu_control=5'b00011, grc=1, r_out=1.
   - T5: zlo_out=gra=r_in=1.
   - Next cycle is T0 with p_out=1.
2. ld opcode 00000 → 8-cycle instruction.
   - T5: mar_en=1.
   - T6: read=mdr_en=1.
   - T7: mdr_out=gra=r_in=1.
   - write stays 0 throughout.
3. st opcode 00010 → write=1 only in T7; T6 has mdr_en=1 with read=0.
4. br opcode 10010 with con_ff=0, then again with con_ff=1:
   - pc_en=0 in T6 for the first; pc_en=zlo_out=1 in T6 for the second.
   - con_in=1 only in T3.
5. stop=1 pulsed during T4 of an add → instruction completes T5, then run=0 (HALT).
   - Holds HALT until start=1; next cycle is T0 with run=1.
6. halt opcode 11010 → HALT after T3. Also: clr=0 mid-T6 of st → all outputs 0 asynchronously and write is never asserted.
